clk_divider: RTL and testbench

- Free-running binary divider: a WIDTH-bit up-counter whose bit i is a square wave at f_clk/2^(i+1).
- Also provides registered-history edge strobes (rising, falling, both) for every divider bit, so downstream logic gets single-cycle enables instead of using derived clocks.
- Sits at the top of test/stimulus infrastructure and feeds slow periodic enables, reseed values and timing ticks to other blocks.

---
 rtl/clk_divider_pkg.sv | 12 +
 rtl/clk_divider_edge_detect.sv | 39 +++
 rtl/clk_divider.sv | 49 ++++
 tb/tb_clk_divider.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/clk_divider_pkg.sv
// rtl/clk_divider_pkg.sv - shared constants and parameter checks for the clock divider
package clk_divider_pkg;

  // Widest divider chain supported; the counter and history registers are sized from WIDTH.
  localparam int WIDTH_MAX = 64;

  // Legal divider widths are 1..WIDTH_MAX.
  function automatic bit width_ok(input int w);
    return (w >= 1) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/clk_divider_edge_detect.sv
// rtl/clk_divider_edge_detect.sv - per-bit rising/falling/both strobes from registered history
module clk_divider_edge_detect
  import clk_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] rising,
  output logic [WIDTH-1:0] falling,
  output logic [WIDTH-1:0] both
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  // Next history value is simply the current bus value.
  always_comb begin
    prev_d = in;
  end

  // History register; cleared together with the source so reset never yields a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // Strobes are combinational so they line up with the cycle in which the bus changes.
  always_comb begin
    rising  = in & ~prev_q;
    falling = ~in & prev_q;
    both    = rising | falling;
  end

endmodule

// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - free-running binary divider with single-cycle edge strobes per stage
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rising,
  output logic [WIDTH-1:0] falling,
  output logic [WIDTH-1:0] both
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("clk_divider: WIDTH must be in 1..%0d", WIDTH_MAX);
  end

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Plain increment; all-ones naturally wraps to zero with no extra cycle.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
  end

  // Divider counter: bit i toggles at f_clk/2^(i+1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out = cnt_q;

  clk_divider_edge_detect #(
    .WIDTH(WIDTH)
  ) u_edge_detect (
    .clk    (clk),
    .rst    (rst),
    .in     (cnt_q),
    .rising (rising),
    .falling(falling),
    .both   (both)
  );

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - scoreboard bench for clk_divider at WIDTH 4, 32 and 1
module tb_clk_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0]  out4,  rise4,  fall4,  both4;
  logic [31:0] out32, rise32, fall32, both32;
  logic [0:0]  out1,  rise1,  fall1,  both1;

  always #5 clk = ~clk;

  clk_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .out(out4), .rising(rise4), .falling(fall4), .both(both4)
  );
  clk_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .out(out32), .rising(rise32), .falling(fall32), .both(both32)
  );
  clk_divider #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .out(out1), .rising(rise1), .falling(fall1), .both(both1)
  );

  typedef struct {
    logic [63:0] cnt;
    logic [63:0] prev;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_cnt  = '0;
  logic [63:0] m_prev = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    logic [3:0]  o4,  p4;
    logic [31:0] o32, p32;
    logic [0:0]  o1,  p1;
    o4  = e.cnt[3:0];  p4  = e.prev[3:0];
    o32 = e.cnt[31:0]; p32 = e.prev[31:0];
    o1  = e.cnt[0:0];  p1  = e.prev[0:0];
    chk("w4_out",   64'(out4),  64'(o4));
    chk("w4_rise",  64'(rise4), 64'(o4 & ~p4));
    chk("w4_fall",  64'(fall4), 64'(~o4 & p4));
    chk("w4_both",  64'(both4), 64'(o4 ^ p4));
    chk("w32_out",  64'(out32),  64'(o32));
    chk("w32_rise", 64'(rise32), 64'(o32 & ~p32));
    chk("w32_fall", 64'(fall32), 64'(~o32 & p32));
    chk("w32_both", 64'(both32), 64'(o32 ^ p32));
    chk("w1_out",   64'(out1),  64'(o1));
    chk("w1_rise",  64'(rise1), 64'(o1 & ~p1));
    chk("w1_fall",  64'(fall1), 64'(~o1 & p1));
    chk("w1_both",  64'(both1), 64'(o1 ^ p1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out4"},  64'(out4),  64'h0);
    chk({tag, "_fall4"}, 64'(fall4), 64'h0);
    chk({tag, "_both4"}, 64'(both4), 64'h0);
    chk({tag, "_out32"}, 64'(out32), 64'h0);
    chk({tag, "_rise32"},64'(rise32),64'h0);
    chk({tag, "_fall32"},64'(fall32),64'h0);
    chk({tag, "_both32"},64'(both32),64'h0);
    chk({tag, "_out1"},  64'(out1),  64'h0);
    chk({tag, "_both1"}, 64'(both1), 64'h0);
  endtask

  // One clock: model advances at the edge, expectation is queued, then compared at the falling edge.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    if (rst) begin
      m_cnt  = '0;
      m_prev = '0;
    end else begin
      m_prev = m_cnt;
      m_cnt  = m_cnt + 64'd1;
    end
    e.cnt  = m_cnt;
    e.prev = m_prev;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
    else compare(sb.pop_front());
  endtask

  // Short asynchronous pulse between edges; model clears at once like the DUT.
  task automatic mid_reset(input string tag);
    #1 rst = 1'b1;
    m_cnt  = '0;
    m_prev = '0;
    #1 check_all_zero(tag);
    #2 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r3, r9, hi_run, hi_len, dbl3;
    logic prev_r3;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Startup sequence and 4-bit wrap.
    for (int c = 1; c <= 16; c++) begin
      cycle();
      if (c == 1) begin
        chk("c1_out4", 64'(out4), 64'h1); chk("c1_rise4", 64'(rise4), 64'h1);
      end
      if (c == 2) begin
        chk("c2_out4", 64'(out4), 64'h2); chk("c2_rise4", 64'(rise4), 64'h2);
        chk("c2_fall4", 64'(fall4), 64'h1);
      end
      if (c == 3) begin
        chk("c3_out4", 64'(out4), 64'h3); chk("c3_rise4", 64'(rise4), 64'h1);
      end
      if (c == 16) begin
        chk("wrap_out4", 64'(out4), 64'h0); chk("wrap_fall4", 64'(fall4), 64'hF);
        chk("wrap_rise4", 64'(rise4), 64'h0); chk("wrap_both4", 64'(both4), 64'hF);
      end
      if (c >= 2) chk("w1_both_const", 64'(both1), 64'h1);
    end

    // Run up to 0xA5 and reset asynchronously mid-count.
    for (int c = 17; c <= 165; c++) cycle();
    chk("a5_out32", 64'(out32), 64'hA5);
    mid_reset("async");
    for (int c = 1; c <= 3; c++) begin
      cycle();
      chk("resume_out32", 64'(out32), 64'(c));
      chk("resume_fall32", 64'(fall32), (c == 2) ? 64'h1 : 64'h0);
    end

    // Reset held across an edge, then period measurement from a clean start.
    @(negedge clk);
    rst = 1'b1;
    m_cnt = '0; m_prev = '0;
    #1 check_all_zero("hold");
    cycle();
    rst = 1'b0;
    r0 = 0; r3 = 0; r9 = 0; hi_run = 0; hi_len = 0; dbl3 = 0; prev_r3 = 1'b0;
    for (int c = 1; c <= 1024; c++) begin
      cycle();
      if (rise32[0]) r0++;
      if (rise32[3]) r3++;
      if (rise32[9]) r9++;
      if (rise32[3] && prev_r3) dbl3++;
      prev_r3 = rise32[3];
      if (out32[3]) hi_run++;
      else if (hi_run != 0 && hi_len == 0) hi_len = hi_run;
    end
    chk("rise0_count", 64'(r0), 64'd512);
    chk("rise3_count", 64'(r3), 64'd64);
    chk("rise9_count", 64'(r9), 64'd1);
    chk("rise3_width", 64'(dbl3), 64'd0);
    chk("out3_high",   64'(hi_len), 64'd8);

    // Repeated short resets: count restarts at 1 each time.
    for (int k = 0; k < 3; k++) begin
      mid_reset("periodic");
      cycle();
      chk("restart_out32", 64'(out32), 64'h1);
      chk("restart_out4",  64'(out4),  64'h1);
      for (int c = 0; c < 200; c++) cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
